axi4_frame_reader: RTL and testbench
====================================

Name: axi4_frame_reader

Overview:
AXI4 read master (MM-to-Stream) that sits directly downstream of the DDR frame buffers filled by the camera-side writer. On each display frame start it fetches one full frame (320x240 RGB565, 153600 bytes) from the selected buffer in 64-beat INCR bursts of 64-bit words. It pushes every returned word into the HDMI-side line FIFO, issuing a burst only when that FIFO can absorb 64 words.

Parameters:
AXI_ADDR_WIDTH, 32, address width
AXI_DATA_WIDTH, 64, data width (8 bytes/beat)
BURST_BEATS, 64, beats per burst (ARLEN = BURST_BEATS-1)
FRAME_BYTES, 153600, bytes per frame (300 bursts of 512 B)
BUF_OFFSET, 32'h0004_0000, byte offset of buffer 1 from FRAME_BASE_ADDR

Ports:
clk_100Mhz  in  1  sole clock; AXI and FIFO write side
rst  in  1  asynchronous, active-high reset
frame_start  in  1  display frame start level, already synchronous to clk_100Mhz; rising edge used
FRAME_BASE_ADDR  in  32  byte address of buffer 0
buf_select  in  1  buffer to read (0: base, 1: base+BUF_OFFSET); sampled on frame_start edge
ARADDR  out  32  burst address
ARVALID  out  1  address valid
ARREADY  in  1  address ready
ARLEN  out  8  constant 63
ARSIZE  out  3  constant 3'b011
ARBURST  out  2  constant 2'b01 (INCR)
ARCACHE  out  4  constant 4'b0011
ARPROT  out  3  constant 3'b000
RDATA  in  64  read data
RVALID  in  1  read data valid
RREADY  out  1  read data ready
RLAST  in  1  last beat of burst
RRESP  in  2  read response
fifo_din  out  64  word to downstream FIFO (combinational copy of RDATA)
fifo_wr_en  out  1  FIFO write strobe
fifo_prog_full  in  1  high when fewer than 64 free FIFO entries
reader_done  out  1  one-cycle pulse after the last burst of a frame
rd_error  out  1  sticky error flag
frame_overrun  out  1  sticky: frame_start edge arrived while a frame was active
state  out  2  current FSM state
ADDR_OFFSET  out  32  byte offset of the current burst within the frame

Behaviour:
- Reset (async): state=IDLE, ARADDR=0, ARVALID=0, RREADY=0, beat_count=0, ADDR_OFFSET=0, reader_done=0, rd_error=0, frame_overrun=0, latched buffer select=0. Constant outputs are not affected by reset.
- frame_start_pulse = frame_start & ~frame_start_d1, where frame_start_d1 is a register cleared by reset.
- States: IDLE=0, WAIT_SPACE=1, ADDR_SEND=2, DATA_RECV=3.
- IDLE:
  - reader_done returns to 0.
  - On frame_start_pulse: latch buf_select, ADDR_OFFSET<=0, go to WAIT_SPACE.
- WAIT_SPACE:
  - When fifo_prog_full=0, go to ADDR_SEND.
  - In the same cycle, ARADDR<=FRAME_BASE_ADDR + (sel ? BUF_OFFSET : 0) + ADDR_OFFSET.
- ADDR_SEND:
  - ARVALID=1, registered, first asserted on the cycle the state is entered.
  - ARADDR held stable while ARVALID=1. ARVALID never drops before the handshake.
  - On ARVALID & ARREADY: ARVALID<=0, beat_count<=0, go to DATA_RECV.
  - Earliest ARVALID: 2 cycles after the frame_start_pulse cycle.
- DATA_RECV:
  - RREADY=1, registered; set on entry, cleared on exit. Backpressure is unnecessary because 64 free entries were guaranteed beforehand.
  - fifo_wr_en = RVALID & RREADY. Each beat increments beat_count (8-bit).
  - Beat 63 (beat_count==63 with handshake) ends the burst.
    - If ADDR_OFFSET == FRAME_BYTES-512 (153088): reader_done<=1 for one cycle, ADDR_OFFSET<=0, go to IDLE.
    - Otherwise: ADDR_OFFSET<=ADDR_OFFSET+512, go to WAIT_SPACE.
- RLAST check: RLAST=1 on a beat other than 63, or RLAST=0 on beat 63, sets rd_error. Burst termination is still by beat count.
- RRESP!=0 on any beat sets rd_error. The data is still written to the FIFO.
- rd_error and frame_overrun clear only on reset.
- frame_start_pulse while state!=IDLE: ignored (current frame continues), frame_overrun<=1.
- frame_start_pulse in the same cycle reader_done is set: ignored; frame_overrun is not set because state is still DATA_RECV. The next edge starts the next frame.
- buf_select changes mid-frame have no effect until the next accepted frame_start_pulse.
- Reset mid-burst: all outputs return to reset values immediately. The system resets the interconnect together, so no burst completion is required.
- All address arithmetic is 32-bit unsigned; wrap-around is not checked.

Test Plan:
- Reset, then frame_start edge with buf_select=0, FRAME_BASE_ADDR=32'h1000_0000, ARREADY/RVALID always 1, fifo_prog_full=0 -> 300 AR handshakes at 0x1000_0000 + 512k for k=0..299; 19200 fifo_wr_en pulses; reader_done pulses once; state returns to IDLE.
- buf_select=1 -> first ARADDR=32'h1004_0000 and last ARADDR=32'h1006_5600; toggling buf_select mid-frame leaves subsequent addresses unchanged.
- Hold ARREADY=0 for 10 cycles after ARVALID -> ARVALID and ARADDR stay constant for all 10 cycles; handshake on cycle 11; RREADY rises the next cycle.
- fifo_prog_full=1 after burst 5 for 50 cycles -> no ARVALID during those cycles; burst 6 issues 2 cycles after fifo_prog_full falls with ARADDR offset 3072.
- RVALID gapped randomly; RRESP=2'b10 on one beat; RLAST early on beat 40 of one burst -> rd_error=1 and sticky; every burst still yields exactly 64 fifo_wr_en pulses; frame completes.
- Second frame_start edge during burst 100 -> frame_overrun=1; frame finishes normally. Separately, assert rst during DATA_RECV -> ARVALID=0, RREADY=0, state=0 in the same cycle.

Source files
------------

// File: rtl/axi4_frame_reader.sv
// AXI4 read master that streams one frame from a DDR frame buffer into a line FIFO.
// Each display frame start fetches FRAME_BYTES from buffer 0 or 1 in fixed-length INCR
// bursts. A burst is issued only when the FIFO reports room for a whole burst.
//
// Ports:
//   clk_100Mhz, rst          clock, asynchronous active-high reset
//   frame_start              frame start level (rising edge starts a frame)
//   FRAME_BASE_ADDR          byte address of buffer 0
//   buf_select               buffer to read, latched on an accepted frame start
//   AR*                      AXI4 read address channel (length/size/burst/cache/prot constant)
//   R*                       AXI4 read data channel
//   fifo_din, fifo_wr_en     write side of the downstream line FIFO
//   fifo_prog_full           FIFO cannot take another full burst
//   reader_done              one-cycle pulse after the last burst of a frame
//   rd_error, frame_overrun  sticky status flags, cleared only by reset
//   state, ADDR_OFFSET       FSM state and byte offset of the current burst in the frame
module axi4_frame_reader #(
  parameter int unsigned                AXI_ADDR_WIDTH = 32,
  parameter int unsigned                AXI_DATA_WIDTH = 64,
  parameter int unsigned                BURST_BEATS    = 64,
  parameter int unsigned                FRAME_BYTES    = 153600,
  parameter logic [AXI_ADDR_WIDTH-1:0]  BUF_OFFSET     = 32'h0004_0000
) (
  input  logic                      clk_100Mhz,
  input  logic                      rst,
  input  logic                      frame_start,
  input  logic [AXI_ADDR_WIDTH-1:0] FRAME_BASE_ADDR,
  input  logic                      buf_select,
  output logic [AXI_ADDR_WIDTH-1:0] ARADDR,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [7:0]                ARLEN,
  output logic [2:0]                ARSIZE,
  output logic [1:0]                ARBURST,
  output logic [3:0]                ARCACHE,
  output logic [2:0]                ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0] RDATA,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic                      RLAST,
  input  logic [1:0]                RRESP,
  output logic [AXI_DATA_WIDTH-1:0] fifo_din,
  output logic                      fifo_wr_en,
  input  logic                      fifo_prog_full,
  output logic                      reader_done,
  output logic                      rd_error,
  output logic                      frame_overrun,
  output logic [1:0]                state,
  output logic [AXI_ADDR_WIDTH-1:0] ADDR_OFFSET
);

  localparam int unsigned BeatBytes = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] BurstBytes =
      AXI_ADDR_WIDTH'(BURST_BEATS * BeatBytes);
  localparam logic [AXI_ADDR_WIDTH-1:0] LastOffset =
      AXI_ADDR_WIDTH'(FRAME_BYTES - BURST_BEATS * BeatBytes);
  localparam logic [7:0] LastBeat = 8'(BURST_BEATS - 1);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWaitSpace = 2'd1,
    StAddrSend  = 2'd2,
    StDataRecv  = 2'd3
  } state_e;

  state_e                    r_state;
  logic                      r_fs_d1;
  logic                      r_sel;
  logic [AXI_ADDR_WIDTH-1:0] r_araddr;
  logic                      r_arvalid;
  logic                      r_rready;
  logic [7:0]                r_beat_count;
  logic [AXI_ADDR_WIDTH-1:0] r_addr_offset;
  logic                      r_done;
  logic                      r_rd_error;
  logic                      r_overrun;

  logic w_fs_pulse;
  logic w_r_hs;
  logic w_last_beat;
  logic w_frame_end;

  assign w_fs_pulse  = frame_start & ~r_fs_d1;
  assign w_r_hs      = RVALID & r_rready;
  assign w_last_beat = (r_beat_count == LastBeat);
  // Final beat of the final burst: the frame completes this cycle.
  assign w_frame_end = w_r_hs & w_last_beat & (r_addr_offset == LastOffset);

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_fs_d1       <= 1'b0;
      r_sel         <= 1'b0;
      r_araddr      <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_beat_count  <= '0;
      r_addr_offset <= '0;
      r_done        <= 1'b0;
      r_rd_error    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_fs_d1 <= frame_start;
      r_done  <= 1'b0;

      // An edge on the completing beat is dropped silently; the next edge starts a frame.
      if (w_fs_pulse && (r_state != StIdle) && !w_frame_end) r_overrun <= 1'b1;

      // Bad RLAST placement or a non-OKAY response is flagged; the burst still ends by count.
      if (w_r_hs && ((RLAST != w_last_beat) || (RRESP != 2'b00))) r_rd_error <= 1'b1;

      case (r_state)
        StIdle: begin
          if (w_fs_pulse) begin
            r_sel         <= buf_select;
            r_addr_offset <= '0;
            r_state       <= StWaitSpace;
          end
        end
        StWaitSpace: begin
          if (!fifo_prog_full) begin
            r_araddr  <= FRAME_BASE_ADDR + (r_sel ? BUF_OFFSET : '0) + r_addr_offset;
            r_arvalid <= 1'b1;
            r_state   <= StAddrSend;
          end
        end
        StAddrSend: begin
          if (r_arvalid && ARREADY) begin
            r_arvalid    <= 1'b0;
            r_beat_count <= '0;
            r_rready     <= 1'b1;
            r_state      <= StDataRecv;
          end
        end
        StDataRecv: begin
          if (w_r_hs) begin
            r_beat_count <= r_beat_count + 8'd1;
            if (w_last_beat) begin
              r_rready <= 1'b0;
              if (r_addr_offset == LastOffset) begin
                r_done        <= 1'b1;
                r_addr_offset <= '0;
                r_state       <= StIdle;
              end else begin
                r_addr_offset <= r_addr_offset + BurstBytes;
                r_state       <= StWaitSpace;
              end
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ARADDR        = r_araddr;
  assign ARVALID       = r_arvalid;
  assign ARLEN         = LastBeat;
  assign ARSIZE        = 3'($clog2(BeatBytes));
  assign ARBURST       = 2'b01;
  assign ARCACHE       = 4'b0011;
  assign ARPROT        = 3'b000;
  assign RREADY        = r_rready;
  // 64 free entries were guaranteed before the burst, so the FIFO never needs to stall R.
  assign fifo_din      = RDATA;
  assign fifo_wr_en    = w_r_hs;
  assign reader_done   = r_done;
  assign rd_error      = r_rd_error;
  assign frame_overrun = r_overrun;
  assign state         = r_state;
  assign ADDR_OFFSET   = r_addr_offset;

endmodule

// File: tb/tb_axi4_frame_reader.sv
// Bench for axi4_frame_reader: an AXI slave responder, a frame-level reference model with a
// per-cycle compare process, and a directed sequence with literal expectations.
module tb_axi4_frame_reader;

  logic        clk;
  logic        rst;
  logic        frame_start;
  logic [31:0] FRAME_BASE_ADDR;
  logic        buf_select;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic [3:0]  ARCACHE;
  logic [2:0]  ARPROT;
  logic [63:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        RLAST;
  logic [1:0]  RRESP;
  logic [63:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_prog_full;
  logic        reader_done;
  logic        rd_error;
  logic        frame_overrun;
  logic [1:0]  state;
  logic [31:0] ADDR_OFFSET;

  axi4_frame_reader dut (
    .clk_100Mhz      (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .FRAME_BASE_ADDR (FRAME_BASE_ADDR),
    .buf_select      (buf_select),
    .ARADDR          (ARADDR),
    .ARVALID         (ARVALID),
    .ARREADY         (ARREADY),
    .ARLEN           (ARLEN),
    .ARSIZE          (ARSIZE),
    .ARBURST         (ARBURST),
    .ARCACHE         (ARCACHE),
    .ARPROT          (ARPROT),
    .RDATA           (RDATA),
    .RVALID          (RVALID),
    .RREADY          (RREADY),
    .RLAST           (RLAST),
    .RRESP           (RRESP),
    .fifo_din        (fifo_din),
    .fifo_wr_en      (fifo_wr_en),
    .fifo_prog_full  (fifo_prog_full),
    .reader_done     (reader_done),
    .rd_error        (rd_error),
    .frame_overrun   (frame_overrun),
    .state           (state),
    .ADDR_OFFSET     (ADDR_OFFSET)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- AXI slave responder ----------------
  int ar_stall_req = 0;
  int stall_seen   = 0;
  bit s_pending    = 0;
  int s_beat       = 0;
  int s_ar_count   = 0;
  bit s_r_hs       = 0;
  bit gaps_on      = 0;
  int inj_rresp_burst = -1, inj_rresp_beat = -1;
  int inj_rlast_burst = -1, inj_rlast_beat = -1;

  initial begin
    int idx;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RLAST = 1'b0; RRESP = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_pending = 0; s_beat = 0; stall_seen = 0; s_r_hs = 0;
      end else begin
        s_r_hs = RVALID && RREADY;
        if (ARVALID && ARREADY) begin
          s_pending = 1; s_beat = 0; s_ar_count++; stall_seen = 0; ar_stall_req = 0;
        end else if (ARVALID) begin
          stall_seen++;
        end
        if (s_r_hs) begin
          s_beat++;
          if (s_beat == 64) begin s_beat = 0; s_pending = 0; end
        end
      end
      @(posedge clk);
      #1;
      ARREADY = (stall_seen >= ar_stall_req);
      idx = s_ar_count - 1;
      if (s_pending && RVALID && !s_r_hs) begin
        // beat still waiting for acceptance: hold it
      end else if (s_pending && (!gaps_on || $urandom_range(0, 3) != 0)) begin
        RVALID = 1'b1;
        RDATA  = {16'(idx), 16'(s_beat), $urandom};
        RLAST  = (s_beat == 63) || (idx == inj_rlast_burst && s_beat == inj_rlast_beat);
        RRESP  = (idx == inj_rresp_burst && s_beat == inj_rresp_beat) ? 2'b10 : 2'b00;
      end else begin
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
      end
    end
  end

  // ---------------- Frame-level reference model and per-cycle compare ----------------
  int          cyc = 0;
  bit          m_active, m_in_burst, m_sel;
  logic [31:0] m_base;
  int          m_k, m_beats;
  bit          exp_done, exp_err, exp_ovr;
  bit          prev_fs, prev_arv, prev_arr, prev_pf;
  logic [31:0] prev_addr;
  bit          mon_ending, mon_fs_edge, mon_next_in_burst;
  logic [31:0] exp_addr;

  int          f_n_ar, f_n_wr, f_n_done, f_t_edge, f_t_first_arv, f_arv_cyc0, f_rise6_cyc;
  logic [31:0] f_first_addr, f_last_addr, f_rise6_off;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        m_active = 0; m_in_burst = 0; m_k = 0; m_beats = 0;
        exp_done = 0; exp_err = 0; exp_ovr = 0;
        prev_fs = 0; prev_arv = 0; prev_arr = 0; prev_pf = 1; prev_addr = '0;
      end else begin
        check("reader_done", reader_done, exp_done);
        check("rd_error", rd_error, exp_err);
        check("frame_overrun", frame_overrun, exp_ovr);
        check("rready", RREADY, m_in_burst);
        check("fifo_wr_en", fifo_wr_en, RVALID && m_in_burst);
        if (fifo_wr_en) check("fifo_din", fifo_din, RDATA);
        if (!m_active) check("state_idle", state, 0);
        if (m_in_burst) check("state_recv", state, 3);
        if (!m_active || m_in_burst) check("arvalid_quiet", ARVALID, 0);
        if (prev_arv && !prev_arr) begin
          check("arvalid_hold", ARVALID, 1);
          check("araddr_hold", ARADDR, prev_addr);
        end
        if (ARVALID) begin
          check("state_addr", state, 2);
          check("addr_offset", ADDR_OFFSET, 64'(512 * m_k));
          if (m_k == 0) f_arv_cyc0++;
        end
        if (ARVALID && !prev_arv) begin
          check("ar_needs_space", prev_pf, 0);
          if (f_t_first_arv < 0) f_t_first_arv = cyc;
          if (m_k == 6 && f_rise6_cyc < 0) begin
            f_rise6_cyc = cyc;
            f_rise6_off = ADDR_OFFSET;
          end
        end

        exp_done = 0;
        mon_next_in_burst = m_in_burst;
        if (ARVALID && ARREADY) begin
          exp_addr = m_base + (m_sel ? 32'h0004_0000 : 32'h0) + 32'(512 * m_k);
          check("araddr", ARADDR, exp_addr);
          if (f_n_ar == 0) f_first_addr = ARADDR;
          f_last_addr = ARADDR;
          f_n_ar++;
          m_k++;
          m_beats = 0;
          mon_next_in_burst = 1;
        end

        mon_ending = 0;
        if (RVALID && m_in_burst) begin
          if (RRESP != 2'b00 || RLAST != (m_beats == 63)) exp_err = 1;
          m_beats++;
          f_n_wr++;
          if (m_beats == 64) begin
            m_beats = 0;
            mon_next_in_burst = 0;
            if (m_k == 300) begin mon_ending = 1; exp_done = 1; end
          end
        end
        if (reader_done) f_n_done++;

        mon_fs_edge = frame_start && !prev_fs;
        if (mon_fs_edge && !mon_ending) begin
          if (m_active) exp_ovr = 1;
          else begin
            m_active = 1; m_sel = buf_select; m_base = FRAME_BASE_ADDR; m_k = 0;
            f_t_edge = cyc;
          end
        end
        if (mon_ending) m_active = 0;
        m_in_burst = mon_next_in_burst;
        prev_fs = frame_start; prev_arv = ARVALID; prev_arr = ARREADY;
        prev_pf = fifo_prog_full; prev_addr = ARADDR;
      end
    end
  end

  // ---------------- Directed sequence ----------------
  function automatic int progress(input int which);
    case (which)
      0:       return f_n_wr;
      1:       return f_n_ar;
      2:       return f_n_done;
      default: return f_rise6_cyc + 1;
    endcase
  endfunction

  task automatic wait_for(input int which, input int target, input int budget,
                          input string name);
    int n;
    n = 0;
    while (progress(which) < target && n < budget) begin
      tick();
      n++;
    end
    n_checks++;
    if (progress(which) >= target) n_pass++;
    else $display("FAIL %s: reached %0d, required %0d within %0d cycles", name,
                  progress(which), target, budget);
  endtask

  task automatic clear_stats();
    f_n_ar = 0; f_n_wr = 0; f_n_done = 0; f_t_edge = 0; f_t_first_arv = -1;
    f_arv_cyc0 = 0; f_rise6_cyc = -1; f_first_addr = '0; f_last_addr = '0;
    f_rise6_off = '0; s_ar_count = 0;
  endtask

  task automatic start_frame(input bit sel);
    buf_select  = sel;
    frame_start = 1'b1;
    tick();
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the sequence ended");
    $fatal(1);
  end

  initial begin
    int pf_fall;
    rst = 1'b1; frame_start = 1'b0; buf_select = 1'b0;
    FRAME_BASE_ADDR = 32'h1000_0000; fifo_prog_full = 1'b0;
    clear_stats();
    repeat (3) tick();
    check("rst_state", state, 0);
    check("rst_arvalid", ARVALID, 0);
    check("rst_rready", RREADY, 0);
    check("rst_araddr", ARADDR, 0);
    check("rst_offset", ADDR_OFFSET, 0);
    check("rst_done", reader_done, 0);
    check("rst_err", rd_error, 0);
    check("rst_ovr", frame_overrun, 0);
    check("arlen", ARLEN, 8'd63);
    check("arsize", ARSIZE, 3'b011);
    check("arburst", ARBURST, 2'b01);
    check("arcache", ARCACHE, 4'b0011);
    check("arprot", ARPROT, 3'b000);
    rst = 1'b0;
    repeat (3) tick();

    // Frame 1: buffer 0, no backpressure
    clear_stats();
    start_frame(1'b0);
    wait_for(2, 1, 40000, "f1_done");
    repeat (5) tick();
    check("f1_ar_count", f_n_ar, 300);
    check("f1_wr_count", f_n_wr, 19200);
    check("f1_done_count", f_n_done, 1);
    check("f1_first_addr", f_first_addr, 32'h1000_0000);
    check("f1_last_addr", f_last_addr, 32'h1002_5600);
    check("f1_start_latency", f_t_first_arv - f_t_edge, 2);
    check("f1_state_idle", state, 0);
    check("f1_offset_idle", ADDR_OFFSET, 0);
    check("f1_err", rd_error, 0);

    // Frame 2: buffer 1 with AR stall, FIFO full window, gaps, faults, overrun
    clear_stats();
    ar_stall_req = 10;
    gaps_on = 1;
    inj_rresp_burst = 10; inj_rresp_beat = 7;
    inj_rlast_burst = 20; inj_rlast_beat = 40;
    start_frame(1'b1);
    wait_for(1, 1, 200, "f2_first_ar");
    check("f2_ar_stall_cycles", f_arv_cyc0, 11);
    wait_for(0, 6 * 64, 3000, "f2_burst5_done");
    fifo_prog_full = 1'b1;
    repeat (50) tick();
    check("f2_no_ar_while_full", f_n_ar, 6);
    fifo_prog_full = 1'b0;
    pf_fall = cyc + 1;
    wait_for(3, 1, 100, "f2_burst6_ar");
    check("f2_burst6_latency", f_rise6_cyc - pf_fall, 1);
    check("f2_burst6_offset", f_rise6_off, 3072);
    check("f2_err_before_fault", rd_error, 0);
    wait_for(0, 50 * 64, 10000, "f2_burst50");
    buf_select = 1'b0;
    wait_for(0, 100 * 64 + 10, 10000, "f2_burst100");
    frame_start = 1'b1;
    repeat (3) tick();
    frame_start = 1'b0;
    check("f2_overrun", frame_overrun, 1);
    wait_for(2, 1, 40000, "f2_done");
    repeat (5) tick();
    check("f2_ar_count", f_n_ar, 300);
    check("f2_wr_count", f_n_wr, 19200);
    check("f2_done_count", f_n_done, 1);
    check("f2_first_addr", f_first_addr, 32'h1004_0000);
    check("f2_last_addr", f_last_addr, 32'h1006_5600);
    check("f2_err_sticky", rd_error, 1);
    check("f2_ovr_sticky", frame_overrun, 1);
    check("f2_state_idle", state, 0);
    gaps_on = 0;
    inj_rresp_burst = -1; inj_rlast_burst = -1;

    // Frame 3: reset in the middle of a burst
    clear_stats();
    start_frame(1'b0);
    wait_for(0, 5, 300, "f3_in_burst");
    check("f3_pre_state", state, 3);
    check("f3_pre_rready", RREADY, 1);
    rst = 1'b1;
    #1;
    check("f3_rst_arvalid", ARVALID, 0);
    check("f3_rst_rready", RREADY, 0);
    check("f3_rst_state", state, 0);
    check("f3_rst_err", rd_error, 0);
    check("f3_rst_ovr", frame_overrun, 0);
    check("f3_rst_offset", ADDR_OFFSET, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("f3_post_state", state, 0);
    check("f3_post_arvalid", ARVALID, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
